cache_req_dispatcher: RTL

Downstream consumer of the 8-bit request queue in the cache controller. It pops one request byte at a time, decodes it into a read/write cache access, and issues it to the cache lookup stage over a valid/ready handshake. It then waits for the cache response and keeps saturating hit/miss statistics. A watchdog flags a lost response.

---
 rtl/cache_ctrl_pkg.sv | 17 +
 rtl/cache_req_dispatcher_sat_counter.sv | 32 +++
 rtl/cache_req_dispatcher.sv | 127 ++++++++++++
 3 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the cache controller request path: FSM state encoding
// and the layout of a request-queue entry.
package cache_ctrl_pkg;

   localparam int DEFAULT_DATA_W = 8;
   localparam int REQ_WE_BIT     = DEFAULT_DATA_W - 1;
   localparam int REQ_ADDR_MSB   = DEFAULT_DATA_W - 2;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      POP       = 3'd1,
      CAPTURE   = 3'd2,
      ISSUE     = 3'd3,
      WAIT_RESP = 3'd4
   } disp_state_t;

endpackage

// File: rtl/cache_req_dispatcher_sat_counter.sv
// Saturating event counter: it counts up on inc and holds at all-ones.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {CNT_W{1'b1}})) begin
         count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         count_d = count_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= {CNT_W{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/cache_req_dispatcher.sv
// Pops request bytes from the queue, issues them to cache lookup over valid/ready,
// waits for the response with a watchdog, and keeps saturating hit/miss counts.
module cache_req_dispatcher
   import cache_ctrl_pkg::*;
#(
   parameter int DATA_W  = DEFAULT_DATA_W,
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              q_empty,
   input  logic [DATA_W-1:0] q_data,
   output logic              q_read_en,
   output logic              req_valid,
   input  logic              req_ready,
   output logic              req_we,
   output logic [DATA_W-2:0] req_addr,
   input  logic              resp_valid,
   input  logic              resp_hit,
   input  logic              clr_err,
   output logic              busy,
   output logic              timeout_err,
   output logic [CNT_W-1:0]  hit_count,
   output logic [CNT_W-1:0]  miss_count
);

   // Field positions follow the configured width, matching the package layout at the default width.
   localparam int WE_BIT   = DATA_W - 1;
   localparam int ADDR_MSB = DATA_W - 2;
   localparam int TMR_W    = $clog2(TIMEOUT);

   disp_state_t       state_q, state_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic              req_we_q, req_we_d;
   logic [DATA_W-2:0] req_addr_q, req_addr_d;
   logic              err_q, err_d;
   logic              hit_inc, miss_inc;

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      req_we_d   = req_we_q;
      req_addr_d = req_addr_q;
      err_d      = err_q;
      hit_inc    = 1'b0;
      miss_inc   = 1'b0;
      // A clear is applied first so that a watchdog set in the same cycle overrides it.
      if (clr_err) begin
         err_d = 1'b0;
      end
      case (state_q)
         IDLE: begin
            if (enable && !q_empty) begin
               state_d = POP;
            end
         end
         POP: begin
            state_d = CAPTURE;
         end
         CAPTURE: begin
            req_we_d   = q_data[WE_BIT];
            req_addr_d = q_data[ADDR_MSB:0];
            state_d    = ISSUE;
         end
         ISSUE: begin
            if (req_ready) begin
               timer_d = {TMR_W{1'b0}};
               state_d = WAIT_RESP;
            end
         end
         WAIT_RESP: begin
            timer_d = timer_q + {{(TMR_W-1){1'b0}}, 1'b1};
            if (resp_valid) begin
               hit_inc  = resp_hit;
               miss_inc = !resp_hit;
               state_d  = IDLE;
            end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         timer_q    <= {TMR_W{1'b0}};
         req_we_q   <= 1'b0;
         req_addr_q <= {(DATA_W-1){1'b0}};
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         req_we_q   <= req_we_d;
         req_addr_q <= req_addr_d;
         err_q      <= err_d;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (hit_inc),
      .count (hit_count)
   );

   sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (miss_inc),
      .count (miss_count)
   );

   assign q_read_en   = (state_q == POP);
   assign req_valid   = (state_q == ISSUE);
   assign busy        = (state_q != IDLE);
   assign req_we      = req_we_q;
   assign req_addr    = req_addr_q;
   assign timeout_err = err_q;

endmodule
